// File: rtl/mem_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter_if
//   Bundles the three handshakes that meet at the memory request arbiter:
//     if_*  : I-cache fetch port (level request, one-cycle done pulse)
//     ls_*  : load/store buffer port (level request, one-cycle done pulse)
//     mc_*  : byte-serial memory controller (mc_en held until mc_done pulse)
//   modport master : the arbiter's view (drives mc_*, if_done/data, ls_done/rdata)
//   modport slave  : the surrounding requesters and controller
// ---------------------------------------------------------------------------
interface mem_req_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;

    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    logic        mc_en;
    logic        mc_we;
    logic [2:0]  mc_size;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic        mc_done;
    logic [31:0] mc_rdata;

    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
               mc_done, mc_rdata,
        output if_done, if_data, ls_done, ls_rdata,
               mc_en, mc_we, mc_size, mc_addr, mc_wdata
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
               mc_done, mc_rdata,
        input  if_done, if_data, ls_done, ls_rdata,
               mc_en, mc_we, mc_size, mc_addr, mc_wdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//   Shares the byte-serial memory controller between the I-cache fetch port
//   and the LSB. One request is outstanding at a time; the winner's fields are
//   latched into the mc_* registers while in flight and the completion is
//   routed back to the owner. Fetch and load responses are dropped when a
//   pipeline clear arrives while they are in flight; stores always complete.
//
//   Ports:
//     clk    - system clock
//     rst    - synchronous, active-high reset
//     rdy    - global enable; low freezes all state and outputs
//     clear  - pipeline flush
//     bus    - mem_req_arbiter_if.master (if_*, ls_*, mc_* handshakes)
//
//   Parameter:
//     STARVE_LIMIT - consecutive LSB grants with if_req pending before IF is
//                    forced (1..15); only used with ARB_STARVE_GUARD_EN.
//
//   Build option:
//     ARB_STARVE_GUARD_EN defined   : starvation counter forces an IF grant.
//     ARB_STARVE_GUARD_EN undefined : strict priority LSB > IF.
// ---------------------------------------------------------------------------
module mem_req_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    mem_req_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
        $error("mem_req_arbiter: STARVE_LIMIT must be in 1..15");
    end

    state_t      state_q,    state_d;
    owner_t      owner_q,    owner_d;
    logic        mc_en_q,    mc_en_d;
    logic        mc_we_q,    mc_we_d;
    logic [2:0]  mc_size_q,  mc_size_d;
    logic [31:0] mc_addr_q,  mc_addr_d;
    logic [31:0] mc_wdata_q, mc_wdata_d;
    logic        if_done_q,  if_done_d;
    logic [31:0] if_data_q,  if_data_d;
    logic        ls_done_q,  ls_done_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        force_if;
`endif

    logic if_live;
    logic ls_live;
    logic grant_if;
    logic grant_ls;
    logic pulse_busy;
    logic droppable;

    always_comb begin
        if_live    = bus.if_req && !clear;
        ls_live    = bus.ls_req;
        // A done pulse is on the outputs this cycle: hold off the next grant so
        // the requester can drop its level request first.
        pulse_busy = if_done_q || ls_done_q;
        droppable  = (owner_q == OWN_IF) || !mc_we_q;

`ifdef ARB_STARVE_GUARD_EN
        force_if = if_live && (starve_cnt_q == 4'(STARVE_LIMIT));
        grant_ls = ls_live && !force_if;
        grant_if = if_live && !grant_ls;
`else
        grant_ls = ls_live;
        grant_if = if_live && !ls_live;
`endif
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        mc_en_d    = mc_en_q;
        mc_we_d    = mc_we_q;
        mc_size_d  = mc_size_q;
        mc_addr_d  = mc_addr_q;
        mc_wdata_d = mc_wdata_q;
        if_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_done_d  = 1'b0;
        ls_rdata_d = ls_rdata_q;
`ifdef ARB_STARVE_GUARD_EN
        starve_cnt_d = starve_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
`ifdef ARB_STARVE_GUARD_EN
                if (!bus.if_req) begin
                    starve_cnt_d = '0;
                end
`endif
                if (!pulse_busy) begin
                    if (grant_ls) begin
                        owner_d    = OWN_LS;
                        mc_en_d    = 1'b1;
                        mc_we_d    = bus.ls_we;
                        mc_size_d  = bus.ls_size;
                        mc_addr_d  = bus.ls_addr;
                        mc_wdata_d = bus.ls_wdata;
                        state_d    = S_WAIT;
`ifdef ARB_STARVE_GUARD_EN
                        if (bus.if_req && (starve_cnt_q != 4'(STARVE_LIMIT))) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
`endif
                    end else if (grant_if) begin
                        owner_d    = OWN_IF;
                        mc_en_d    = 1'b1;
                        mc_we_d    = 1'b0;
                        mc_size_d  = 3'd4;
                        mc_addr_d  = bus.if_addr;
                        mc_wdata_d = '0;
                        state_d    = S_WAIT;
`ifdef ARB_STARVE_GUARD_EN
                        starve_cnt_d = '0;
`endif
                    end
                end
            end

            S_WAIT: begin
                if (clear && droppable) begin
                    // Controller is not aborted; wait out its completion.
                    if (bus.mc_done) begin
                        mc_en_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (bus.mc_done) begin
                    mc_en_d = 1'b0;
                    state_d = S_IDLE;
                    if (owner_q == OWN_IF) begin
                        if_done_d = 1'b1;
                        if_data_d = bus.mc_rdata;
                    end else begin
                        ls_done_d = 1'b1;
                        if (!mc_we_q) begin
                            ls_rdata_d = bus.mc_rdata;
                        end
                    end
                end
            end

            S_DROP: begin
                if (bus.mc_done) begin
                    mc_en_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                mc_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_IF;
            mc_en_q    <= 1'b0;
            mc_we_q    <= 1'b0;
            mc_size_q  <= '0;
            mc_addr_q  <= '0;
            mc_wdata_q <= '0;
            if_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve_cnt_q <= '0;
`endif
        end else if (rdy) begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            mc_en_q    <= mc_en_d;
            mc_we_q    <= mc_we_d;
            mc_size_q  <= mc_size_d;
            mc_addr_q  <= mc_addr_d;
            mc_wdata_q <= mc_wdata_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            ls_done_q  <= ls_done_d;
            ls_rdata_q <= ls_rdata_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign bus.mc_en    = mc_en_q;
    assign bus.mc_we    = mc_we_q;
    assign bus.mc_size  = mc_size_q;
    assign bus.mc_addr  = mc_addr_q;
    assign bus.mc_wdata = mc_wdata_q;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_req_arbiter
//   Directed bench for mem_req_arbiter. A table of per-cycle vectors drives the
//   inputs and lists the outputs expected after the following clock edge;
//   hand-written sequences cover grant ordering under contention and reset
//   in the middle of a transfer. Expectations for the grant order follow
//   ARB_STARVE_GUARD_EN.
// ---------------------------------------------------------------------------
module tb_mem_req_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clear;

    int errors = 0;
    int checks = 0;

    mem_req_arbiter_if bus ();

    mem_req_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, clr, ifr;
        logic [31:0] ifa;
        logic        lsr, lwe;
        logic [2:0]  lsz;
        logic [31:0] lsa, lwd;
        logic        mcd;
        logic [31:0] mrd;
        logic        en, we;
        logic [2:0]  sz;
        logic [31:0] ma, wd;
        logic        ifd;
        logic [31:0] ifdat;
        logic        lsd;
        logic [31:0] lsrd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic rdy_i, clr_i, ifr_i, input logic [31:0] ifa_i,
        input logic lsr_i, lwe_i, input logic [2:0] lsz_i,
        input logic [31:0] lsa_i, lwd_i, input logic mcd_i, input logic [31:0] mrd_i,
        input logic en_i, we_i, input logic [2:0] sz_i, input logic [31:0] ma_i, wd_i,
        input logic ifd_i, input logic [31:0] ifdat_i, input logic lsd_i,
        input logic [31:0] lsrd_i);
        vec_t v;
        v.rdy = rdy_i; v.clr = clr_i; v.ifr = ifr_i; v.ifa = ifa_i;
        v.lsr = lsr_i; v.lwe = lwe_i; v.lsz = lsz_i; v.lsa = lsa_i; v.lwd = lwd_i;
        v.mcd = mcd_i; v.mrd = mrd_i;
        v.en = en_i; v.we = we_i; v.sz = sz_i; v.ma = ma_i; v.wd = wd_i;
        v.ifd = ifd_i; v.ifdat = ifdat_i; v.lsd = lsd_i; v.lsrd = lsrd_i;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        rdy = 1'b1; clear = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = '0;
        bus.ls_addr = '0; bus.ls_wdata = '0;
        bus.mc_done = 1'b0; bus.mc_rdata = '0;
    endtask

    task automatic check_outputs(input string name, input vec_t e);
        checks++;
        if (bus.mc_en !== e.en || bus.mc_we !== e.we || bus.mc_size !== e.sz ||
            bus.mc_addr !== e.ma || bus.mc_wdata !== e.wd || bus.if_done !== e.ifd ||
            bus.if_data !== e.ifdat || bus.ls_done !== e.lsd || bus.ls_rdata !== e.lsrd) begin
            errors++;
            $display("FAIL %s: got en=%0b we=%0b sz=%0d addr=%h wd=%h ifd=%0b ifdat=%h lsd=%0b lsrd=%h | want en=%0b we=%0b sz=%0d addr=%h wd=%h ifd=%0b ifdat=%h lsd=%0b lsrd=%h",
                     name, bus.mc_en, bus.mc_we, bus.mc_size, bus.mc_addr, bus.mc_wdata,
                     bus.if_done, bus.if_data, bus.ls_done, bus.ls_rdata,
                     e.en, e.we, e.sz, e.ma, e.wd, e.ifd, e.ifdat, e.lsd, e.lsrd);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, got, want);
        end
    endtask

    function automatic logic exp_if_grant(input int k);
`ifdef ARB_STARVE_GUARD_EN
        return (k == 4);
`else
        return (k < 0);
`endif
    endfunction

    // Both requesters hold their requests; service n grants and check who won each.
    task automatic grant_order(input string tag, input int n);
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 3'd4;
        bus.ls_addr = 32'h0000_0500; bus.ls_wdata = 32'h5555_AAAA;
        for (int k = 0; k < n; k++) begin
            int wait_cyc = 0;
            while (!bus.mc_en && wait_cyc < 20) begin
                @(posedge clk); #1;
                wait_cyc++;
            end
            if (!bus.mc_en) begin
                checks++; errors++;
                $display("FAIL %s grant%0d: got no mc_en want grant within 20 cycles", tag, k);
                return;
            end
            check_bit($sformatf("%s grant%0d is_if", tag, k),
                      bus.mc_addr == 32'h0000_0100, exp_if_grant(k));
            bus.mc_done = 1'b1; bus.mc_rdata = 32'h0000_0042;
            @(posedge clk); #1;
            bus.mc_done = 1'b0;
            check_bit($sformatf("%s done%0d", tag, k),
                      exp_if_grant(k) ? bus.if_done : bus.ls_done, 1'b1);
        end
    endtask

    vec_t zero_v;

    initial begin
        drive_idle();
        rst = 1'b1;
        zero_v = '{default: '0};
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", zero_v);
        rst = 1'b0;

        // rdy clr ifr ifa       lsr lwe lsz lsa       lwd   mcd mrd        | en we sz addr  wd    ifd ifdat      lsd lsrd
        add(1,0,1,32'h1000,      0,0,0,0,0,             0,0,             1,0,4,32'h1000,0,      0,0,0,0);
        for (int i = 0; i < 5; i++)
            add(1,0,1,32'h1000,  0,0,0,0,0,             0,0,             1,0,4,32'h1000,0,      0,0,0,0);
        add(1,0,1,32'h1000,      0,0,0,0,0,             1,32'h00A00093,  0,0,4,32'h1000,0,      1,32'h00A00093,0,0);
        add(1,0,0,0,             0,0,0,0,0,             0,0,             0,0,4,32'h1000,0,      0,32'h00A00093,0,0);
        add(1,0,0,0,             1,1,2,32'h30000,32'hBEEF,0,0,           1,1,2,32'h30000,32'hBEEF,0,32'h00A00093,0,0);
        add(1,1,0,0,             1,1,2,32'h30000,32'hBEEF,0,0,           1,1,2,32'h30000,32'hBEEF,0,32'h00A00093,0,0);
        add(1,0,0,0,             1,1,2,32'h30000,32'hBEEF,1,32'h12345678,0,1,2,32'h30000,32'hBEEF,0,32'h00A00093,1,0);
        add(1,0,0,0,             0,0,0,0,0,             0,0,             0,1,2,32'h30000,32'hBEEF,0,32'h00A00093,0,0);
        add(1,0,0,0,             1,0,1,32'h40,0,        0,0,             1,0,1,32'h40,0,        0,32'h00A00093,0,0);
        add(1,0,0,0,             1,0,1,32'h40,0,        1,32'hFF,        0,0,1,32'h40,0,        0,32'h00A00093,1,32'hFF);
        add(1,0,0,0,             0,0,0,0,0,             0,0,             0,0,1,32'h40,0,        0,32'h00A00093,0,32'hFF);
        add(1,0,1,32'h2000,      0,0,0,0,0,             0,0,             1,0,4,32'h2000,0,      0,32'h00A00093,0,32'hFF);
        add(1,1,0,0,             0,0,0,0,0,             0,0,             1,0,4,32'h2000,0,      0,32'h00A00093,0,32'hFF);
        add(1,0,0,0,             0,0,0,0,0,             0,0,             1,0,4,32'h2000,0,      0,32'h00A00093,0,32'hFF);
        add(1,0,0,0,             0,0,0,0,0,             1,32'hDEAD,      0,0,4,32'h2000,0,      0,32'h00A00093,0,32'hFF);
        add(1,0,1,32'h3000,      0,0,0,0,0,             0,0,             1,0,4,32'h3000,0,      0,32'h00A00093,0,32'hFF);
        add(1,0,1,32'h3000,      0,0,0,0,0,             1,32'h00300013,  0,0,4,32'h3000,0,      1,32'h00300013,0,32'hFF);
        add(1,0,0,0,             0,0,0,0,0,             0,0,             0,0,4,32'h3000,0,      0,32'h00300013,0,32'hFF);
        add(1,0,0,0,             1,0,4,32'h44,0,        0,0,             1,0,4,32'h44,0,        0,32'h00300013,0,32'hFF);
        for (int i = 0; i < 3; i++)
            add(0,0,0,0,         1,0,4,32'h44,0,        0,0,             1,0,4,32'h44,0,        0,32'h00300013,0,32'hFF);
        add(1,0,0,0,             1,0,4,32'h44,0,        1,32'hCAFEF00D,  0,0,4,32'h44,0,        0,32'h00300013,1,32'hCAFEF00D);
        add(1,0,0,0,             0,0,0,0,0,             0,0,             0,0,4,32'h44,0,        0,32'h00300013,0,32'hCAFEF00D);
        add(1,0,0,0,             1,0,2,32'h50,0,        0,0,             1,0,2,32'h50,0,        0,32'h00300013,0,32'hCAFEF00D);
        add(1,1,0,0,             0,0,0,0,0,             1,32'h1111,      0,0,2,32'h50,0,        0,32'h00300013,0,32'hCAFEF00D);
        add(1,1,1,32'h4000,      0,0,0,0,0,             1,32'h2222,      0,0,2,32'h50,0,        0,32'h00300013,0,32'hCAFEF00D);
        add(1,0,1,32'h4000,      0,0,0,0,0,             0,0,             1,0,4,32'h4000,0,      0,32'h00300013,0,32'hCAFEF00D);
        add(1,0,1,32'h4000,      0,0,0,0,0,             1,32'h77,        0,0,4,32'h4000,0,      1,32'h77,0,32'hCAFEF00D);
        add(1,0,1,32'h4004,      0,0,0,0,0,             0,0,             0,0,4,32'h4000,0,      0,32'h77,0,32'hCAFEF00D);
        add(1,0,1,32'h4004,      0,0,0,0,0,             0,0,             1,0,4,32'h4004,0,      0,32'h77,0,32'hCAFEF00D);
        add(1,0,1,32'h4004,      0,0,0,0,0,             1,32'h88,        0,0,4,32'h4004,0,      1,32'h88,0,32'hCAFEF00D);
        add(1,0,0,0,             0,0,0,0,0,             0,0,             0,0,4,32'h4004,0,      0,32'h88,0,32'hCAFEF00D);

        foreach (vecs[i]) begin
            rdy = vecs[i].rdy; clear = vecs[i].clr;
            bus.if_req = vecs[i].ifr; bus.if_addr = vecs[i].ifa;
            bus.ls_req = vecs[i].lsr; bus.ls_we = vecs[i].lwe; bus.ls_size = vecs[i].lsz;
            bus.ls_addr = vecs[i].lsa; bus.ls_wdata = vecs[i].lwd;
            bus.mc_done = vecs[i].mcd; bus.mc_rdata = vecs[i].mrd;
            @(posedge clk); #1;
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        drive_idle();
        @(posedge clk); #1;

        grant_order("order", 6);

        // Reset while a grant is in WAIT, then confirm the starvation count restarts.
        begin
            int wait_cyc = 0;
            while (!bus.mc_en && wait_cyc < 20) begin
                @(posedge clk); #1;
                wait_cyc++;
            end
            check_bit("pre_rst_grant", bus.mc_en, 1'b1);
            rst = 1'b1;
            @(posedge clk); #1;
            check_outputs("rst_mid_wait", zero_v);
            rst = 1'b0;
        end

        grant_order("after_rst", 6);

        drive_idle();
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
